// File: rtl/ship_life_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ship_life_ctrl
//  Description : Player-ship life cycle controller. Tracks lives and sequences
//                the ship through alive, explosion animation, hidden respawn
//                delay and blinking invulnerability, using one shared 8-bit
//                frame counter that is cleared on every state change.
//  Ports       : pclk             - clock, all state changes on rising edge
//                rst              - synchronous active-high reset
//                frame_tick       - one-cycle pulse per video frame
//                start_game       - one-cycle start request
//                is_ship_display  - collision detector output, 0 = ship hit
//                collision_rst    - held high outside ALIVE to park detector
//                ship_visible     - draw ship sprite
//                explosion_active - draw explosion sprite
//                explosion_frame  - explosion sprite index 0..3
//                lives            - remaining lives
//                invulnerable     - post-respawn invulnerability window
//                game_over        - no lives remain
//  Revision    : 1.0 - initial release
// ============================================================================
module ship_life_ctrl #(
  parameter int unsigned INIT_LIVES     = 3,
  parameter int unsigned EXPLODE_STEP   = 8,
  parameter int unsigned RESPAWN_FRAMES = 60,
  parameter int unsigned INVULN_FRAMES  = 120,
  parameter int unsigned BLINK_PERIOD   = 8
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_game,
  input  logic       is_ship_display,
  output logic       collision_rst,
  output logic       ship_visible,
  output logic       explosion_active,
  output logic [1:0] explosion_frame,
  output logic [1:0] lives,
  output logic       invulnerable,
  output logic       game_over
);

  // Elaboration-time parameter sanity checks.
  if (4 * EXPLODE_STEP > 255 || RESPAWN_FRAMES > 255 || INVULN_FRAMES > 255) begin : g_bad_timing
    $error("ship_life_ctrl: timing parameters must fit the 8-bit frame counter");
  end
  if (INIT_LIVES < 1 || INIT_LIVES > 3) begin : g_bad_lives
    $error("ship_life_ctrl: INIT_LIVES must be 1..3");
  end
  if (EXPLODE_STEP < 1 || BLINK_PERIOD < 1) begin : g_bad_step
    $error("ship_life_ctrl: EXPLODE_STEP and BLINK_PERIOD must be at least 1");
  end

  localparam logic [1:0] c_init_lives   = 2'(INIT_LIVES);
  localparam logic [7:0] c_step1        = 8'(EXPLODE_STEP);
  localparam logic [7:0] c_step2        = 8'(2 * EXPLODE_STEP);
  localparam logic [7:0] c_step3        = 8'(3 * EXPLODE_STEP);
  localparam logic [7:0] c_explode_done = 8'(4 * EXPLODE_STEP);
  localparam logic [7:0] c_respawn_done = 8'(RESPAWN_FRAMES);
  localparam logic [7:0] c_invuln_done  = 8'(INVULN_FRAMES);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_ALIVE        = 3'd1,
    ST_EXPLODE      = 3'd2,
    ST_RESPAWN_WAIT = 3'd3,
    ST_INVULN       = 3'd4,
    ST_GAME_OVER    = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic [7:0] fcnt_inc;
  logic [1:0] lives_q, lives_d;

  logic       collision_rst_q, collision_rst_d;
  logic       ship_visible_q, ship_visible_d;
  logic       explosion_active_q, explosion_active_d;
  logic [1:0] explosion_frame_q, explosion_frame_d;
  logic       invulnerable_q, invulnerable_d;
  logic       game_over_q, game_over_d;

  // Next state, counter and lives.
  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    // Timed states never hold fcnt above their limit (all <= 255), so the
    // 8-bit increment cannot wrap where it is compared.
    fcnt_inc = fcnt_q + {7'd0, frame_tick};

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_game) begin
          state_d = ST_ALIVE;
          lives_d = c_init_lives;
        end
      end
      ST_ALIVE: begin
        // A hit beats a coincident frame_tick: the state change clears fcnt.
        if (!is_ship_display) begin
          state_d = ST_EXPLODE;
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
        end
      end
      ST_EXPLODE: begin
        if (fcnt_inc >= c_explode_done)
          state_d = (lives_q == 2'd0) ? ST_GAME_OVER : ST_RESPAWN_WAIT;
      end
      ST_RESPAWN_WAIT: begin
        if (fcnt_inc >= c_respawn_done) state_d = ST_INVULN;
      end
      ST_INVULN: begin
        if (fcnt_inc >= c_invuln_done) state_d = ST_ALIVE;
      end
      default: state_d = ST_IDLE;
    endcase

    fcnt_d = (state_d != state_q) ? 8'd0 : fcnt_inc;
  end

  // Outputs are decoded from the next state so that, once registered, they
  // describe the state the FSM holds after the same edge.
  always_comb begin
    collision_rst_d    = (state_d != ST_ALIVE);
    ship_visible_d     = 1'b0;
    explosion_active_d = 1'b0;
    explosion_frame_d  = 2'd0;
    invulnerable_d     = 1'b0;
    game_over_d        = 1'b0;

    case (state_d)
      ST_ALIVE: ship_visible_d = 1'b1;
      ST_EXPLODE: begin
        explosion_active_d = 1'b1;
        // fcnt stays below 4*EXPLODE_STEP here, so thresholds give the floor.
        if (fcnt_d >= c_step3)      explosion_frame_d = 2'd3;
        else if (fcnt_d >= c_step2) explosion_frame_d = 2'd2;
        else if (fcnt_d >= c_step1) explosion_frame_d = 2'd1;
        else                        explosion_frame_d = 2'd0;
      end
      ST_INVULN: begin
        invulnerable_d = 1'b1;
        ship_visible_d = (((32'(fcnt_d) / BLINK_PERIOD) % 32'd2) == 32'd0);
      end
      ST_GAME_OVER: game_over_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      fcnt_q             <= 8'd0;
      lives_q            <= c_init_lives;
      collision_rst_q    <= 1'b1;
      ship_visible_q     <= 1'b0;
      explosion_active_q <= 1'b0;
      explosion_frame_q  <= 2'd0;
      invulnerable_q     <= 1'b0;
      game_over_q        <= 1'b0;
    end else begin
      state_q            <= state_d;
      fcnt_q             <= fcnt_d;
      lives_q            <= lives_d;
      collision_rst_q    <= collision_rst_d;
      ship_visible_q     <= ship_visible_d;
      explosion_active_q <= explosion_active_d;
      explosion_frame_q  <= explosion_frame_d;
      invulnerable_q     <= invulnerable_d;
      game_over_q        <= game_over_d;
    end
  end

  assign collision_rst    = collision_rst_q;
  assign ship_visible     = ship_visible_q;
  assign explosion_active = explosion_active_q;
  assign explosion_frame  = explosion_frame_q;
  assign lives            = lives_q;
  assign invulnerable     = invulnerable_q;
  assign game_over        = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_ship_life_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ship_life_ctrl
//  Description : Directed self-checking bench for ship_life_ctrl with a
//                phase/tick model checked every cycle plus literal checkpoints.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ship_life_ctrl;

  localparam int INIT_LIVES = 3;
  localparam int ES         = 2;   // explosion step
  localparam int RF         = 4;   // respawn frames
  localparam int IF_FRAMES  = 8;   // invulnerability frames
  localparam int BP         = 2;   // blink half-period

  localparam int P_IDLE = 0, P_ALIVE = 1, P_EXPL = 2, P_RESP = 3, P_INV = 4, P_OVER = 5;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_game = 1'b0;
  logic       is_ship_display = 1'b1;
  logic       collision_rst, ship_visible, explosion_active, invulnerable, game_over;
  logic [1:0] explosion_frame, lives;

  int checks = 0;
  int errors = 0;

  ship_life_ctrl #(
    .INIT_LIVES(INIT_LIVES), .EXPLODE_STEP(ES), .RESPAWN_FRAMES(RF),
    .INVULN_FRAMES(IF_FRAMES), .BLINK_PERIOD(BP)
  ) dut (
    .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .start_game(start_game),
    .is_ship_display(is_ship_display), .collision_rst(collision_rst),
    .ship_visible(ship_visible), .explosion_active(explosion_active),
    .explosion_frame(explosion_frame), .lives(lives),
    .invulnerable(invulnerable), .game_over(game_over)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which phase the ship is in, frame ticks spent in it, and lives.
  int  m_ph = P_IDLE;
  int  m_t = 0;
  int  m_lives = INIT_LIVES;
  bit  m_valid = 1'b0;

  always @(posedge pclk) begin
    if (rst) begin
      m_ph = P_IDLE; m_t = 0; m_lives = INIT_LIVES; m_valid = 1'b1;
    end else begin
      case (m_ph)
        P_IDLE, P_OVER:
          if (start_game) begin m_ph = P_ALIVE; m_t = 0; m_lives = INIT_LIVES; end
        P_ALIVE:
          if (!is_ship_display) begin
            m_ph = P_EXPL; m_t = 0;
            if (m_lives > 0) m_lives = m_lives - 1;
          end
        P_EXPL: begin
          m_t += int'(frame_tick);
          if (m_t >= 4 * ES) begin m_ph = (m_lives == 0) ? P_OVER : P_RESP; m_t = 0; end
        end
        P_RESP: begin
          m_t += int'(frame_tick);
          if (m_t >= RF) begin m_ph = P_INV; m_t = 0; end
        end
        P_INV: begin
          m_t += int'(frame_tick);
          if (m_t >= IF_FRAMES) begin m_ph = P_ALIVE; m_t = 0; end
        end
        default: m_ph = P_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge pclk) begin
    if (m_valid) begin
      chk("m_collision_rst", int'(collision_rst), int'(m_ph != P_ALIVE));
      chk("m_ship_visible", int'(ship_visible),
          int'(m_ph == P_ALIVE || (m_ph == P_INV && ((m_t / BP) % 2) == 0)));
      chk("m_explosion_active", int'(explosion_active), int'(m_ph == P_EXPL));
      chk("m_explosion_frame", int'(explosion_frame), (m_ph == P_EXPL) ? m_t / ES : 0);
      chk("m_lives", int'(lives), m_lives);
      chk("m_invulnerable", int'(invulnerable), int'(m_ph == P_INV));
      chk("m_game_over", int'(game_over), int'(m_ph == P_OVER));
    end
  end

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge pclk);
    frame_tick = 1'b0;
    @(negedge pclk);
  endtask

  task automatic hit();
    is_ship_display = 1'b0;
    @(negedge pclk);
    is_ship_display = 1'b1;
  endtask

  // One full explosion + respawn + invulnerability sequence, no hits.
  task automatic recover();
    for (int i = 0; i < 4 * ES + RF + IF_FRAMES; i++) tick();
  endtask

  int exp_fr[7]  = '{0, 1, 1, 2, 2, 3, 3};
  int exp_vis[8] = '{1, 1, 0, 0, 1, 1, 0, 0};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge pclk);
    @(negedge pclk);
    rst = 1'b0;
    chk("rst_collision_rst", int'(collision_rst), 1);
    chk("rst_lives", int'(lives), 3);
    chk("rst_visible", int'(ship_visible), 0);
    chk("rst_game_over", int'(game_over), 0);

    // Start -> ALIVE
    start_game = 1'b1;
    @(negedge pclk);
    start_game = 1'b0;
    chk("start_visible", int'(ship_visible), 1);
    chk("start_collision_rst", int'(collision_rst), 0);
    chk("start_lives", int'(lives), 3);
    tick(); tick();

    // Hit coincident with frame_tick
    is_ship_display = 1'b0; frame_tick = 1'b1;
    @(negedge pclk);
    is_ship_display = 1'b1; frame_tick = 1'b0;
    chk("hit_expl_active", int'(explosion_active), 1);
    chk("hit_frame", int'(explosion_frame), 0);
    chk("hit_lives", int'(lives), 2);
    chk("hit_visible", int'(ship_visible), 0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("expl_frame_seq", int'(explosion_frame), exp_fr[k-1]);
    end
    tick();
    chk("respawn_expl_off", int'(explosion_active), 0);
    chk("respawn_hidden", int'(ship_visible), 0);

    // RESPAWN_WAIT, then INVULN with hits ignored and a start request ignored
    tick(); tick(); tick();
    chk("respawn_not_inv", int'(invulnerable), 0);
    is_ship_display = 1'b0;
    tick();
    chk("inv_entered", int'(invulnerable), 1);
    chk("inv_vis_0", int'(ship_visible), exp_vis[0]);
    for (int i = 1; i <= 7; i++) begin
      if (i == 4) begin
        start_game = 1'b1;
        @(negedge pclk);
        start_game = 1'b0;
        chk("inv_start_ignored", int'(invulnerable), 1);
        chk("inv_start_lives", int'(lives), 2);
      end
      tick();
      chk("inv_vis_seq", int'(ship_visible), exp_vis[i]);
    end
    is_ship_display = 1'b1;
    tick();
    chk("back_alive_inv", int'(invulnerable), 0);
    chk("back_alive_crst", int'(collision_rst), 0);
    chk("back_alive_vis", int'(ship_visible), 1);

    // Second and third hits
    hit();
    chk("hit2_lives", int'(lives), 1);
    recover();
    hit();
    chk("hit3_lives", int'(lives), 0);
    for (int i = 0; i < 4 * ES; i++) tick();
    chk("over_game_over", int'(game_over), 1);
    chk("over_collision_rst", int'(collision_rst), 1);
    chk("over_visible", int'(ship_visible), 0);
    chk("over_lives", int'(lives), 0);
    is_ship_display = 1'b0;
    @(negedge pclk); @(negedge pclk);
    is_ship_display = 1'b1;
    chk("over_hit_ignored", int'(lives), 0);
    start_game = 1'b1;
    @(negedge pclk);
    start_game = 1'b0;
    chk("restart_lives", int'(lives), 3);
    chk("restart_game_over", int'(game_over), 0);
    chk("restart_visible", int'(ship_visible), 1);

    // Reset mid-explosion at frame 2, with every other input active
    hit();
    tick(); tick(); tick(); tick();
    chk("pre_rst_frame", int'(explosion_frame), 2);
    rst = 1'b1; frame_tick = 1'b1; start_game = 1'b1; is_ship_display = 1'b0;
    @(negedge pclk);
    rst = 1'b0; frame_tick = 1'b0; start_game = 1'b0; is_ship_display = 1'b1;
    chk("mrst_collision_rst", int'(collision_rst), 1);
    chk("mrst_visible", int'(ship_visible), 0);
    chk("mrst_expl", int'(explosion_active), 0);
    chk("mrst_frame", int'(explosion_frame), 0);
    chk("mrst_inv", int'(invulnerable), 0);
    chk("mrst_game_over", int'(game_over), 0);
    chk("mrst_lives", int'(lives), 3);
    tick(); tick();
    chk("idle_stays", int'(collision_rst), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
